// File: rtl/prdct_ctrl_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : prdct_ctrl_pkg                                             |
// | Description : Shared constants and types for the branch-resolution       |
// |               controller and its prediction queue.                      |
// | Ports       : none (package)                                             |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package prdct_ctrl_pkg;

    localparam logic        JumpEnable    = 1'b1;
    localparam logic        JumpDisable   = 1'b0;
    localparam logic [31:0] ZeroWord      = 32'h0000_0000;
    localparam int          InstAddrBus   = 32;
    localparam int          PrdQueueDepth = 4;
    localparam int          FlushCyc      = 2;

    typedef logic [InstAddrBus-1:0] inst_addr_t;

    // One outstanding prediction issued by ID.
    typedef struct packed {
        logic       jump_en;
        inst_addr_t instaddr;
        inst_addr_t target;
    } pred_rec_t;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_FLUSH = 1'b1
    } state_e;

endpackage : prdct_ctrl_pkg
`default_nettype wire

// File: rtl/prdct_ctrl_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : prdct_ctrl_if                                              |
// | Description : Bundle between ID predictor / EX branch unit / ctrl and    |
// |               the branch-resolution controller.                          |
// | Ports       : ID push record, EX resolve record, redirect/flush/stall    |
// |               controls, statistics counters and sticky error.            |
// |               master = pipeline side, slave = controller.                |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
interface prdct_ctrl_if #(
    parameter int CNT_W = 32
);
    import prdct_ctrl_pkg::*;

    logic             id_push_i;
    logic             id_jump_en_i;
    inst_addr_t       id_instaddr_i;
    inst_addr_t       id_target_i;
    logic             ex_resolve_i;
    logic             ex_taken_i;
    inst_addr_t       ex_target_i;
    inst_addr_t       ex_instaddr_i;
    logic             stall_id_o;
    logic             redirect_o;
    inst_addr_t       redirect_addr_o;
    logic             flush_o;
    logic             mispred_o;
    logic [CNT_W-1:0] br_cnt_o;
    logic [CNT_W-1:0] mispred_cnt_o;
    logic             err_o;

    modport master (
        output id_push_i, id_jump_en_i, id_instaddr_i, id_target_i,
        output ex_resolve_i, ex_taken_i, ex_target_i, ex_instaddr_i,
        input  stall_id_o, redirect_o, redirect_addr_o, flush_o,
        input  mispred_o, br_cnt_o, mispred_cnt_o, err_o
    );

    modport slave (
        input  id_push_i, id_jump_en_i, id_instaddr_i, id_target_i,
        input  ex_resolve_i, ex_taken_i, ex_target_i, ex_instaddr_i,
        output stall_id_o, redirect_o, redirect_addr_o, flush_o,
        output mispred_o, br_cnt_o, mispred_cnt_o, err_o
    );

endinterface : prdct_ctrl_if
`default_nettype wire

// File: rtl/prdct_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : prdct_fifo                                                 |
// | Description : In-order queue of outstanding prediction records.          |
// | Ports       : clk, rstn      - clock, synchronous active-low reset       |
// |               i_push/i_wdata - write record at tail                      |
// |               i_pop          - drop head                                 |
// |               i_clear        - empty the queue (wins over push/pop)      |
// |               o_full/o_empty - occupancy flags                           |
// |               o_head         - combinational head record                 |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module prdct_fifo
    import prdct_ctrl_pkg::*;
#(
    parameter int DEPTH = PrdQueueDepth
) (
    input  wire logic      clk,
    input  wire logic      rstn,
    input  wire logic      i_push,
    input  wire logic      i_pop,
    input  wire logic      i_clear,
    input  wire pred_rec_t i_wdata,
    output logic           o_full,
    output logic           o_empty,
    output pred_rec_t      o_head
);

    // Extra MSB is the wrap bit that separates full from empty.
    localparam int PW = $clog2(DEPTH) + 1;

    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    pred_rec_t     r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else if (i_clear) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (i_push) r_wptr <= r_wptr + PW'(1);
            if (i_pop)  r_rptr <= r_rptr + PW'(1);
        end
    end

    // Storage needs no reset: entries are only read between valid pointers.
    always_ff @(posedge clk) begin
        if (i_push && !i_clear) r_mem[r_wptr[PW-2:0]] <= i_wdata;
    end

    assign o_empty = (r_wptr == r_rptr);
    assign o_full  = (r_wptr[PW-1] != r_rptr[PW-1]) &&
                     (r_wptr[PW-2:0] == r_rptr[PW-2:0]);
    assign o_head  = r_mem[r_rptr[PW-2:0]];

endmodule : prdct_fifo
`default_nettype wire

// File: rtl/prdct_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : prdct_ctrl                                                 |
// | Description : Branch-resolution controller. Queues ID predictions,       |
// |               checks them against EX outcomes, issues registered         |
// |               redirect plus multi-cycle flush on a misprediction and     |
// |               keeps saturating branch / misprediction counters.          |
// | Ports       : clk, rstn - clock, synchronous active-low reset            |
// |               bus       - prdct_ctrl_if.slave (push, resolve, redirect,  |
// |                           flush, stall, counters, err)                   |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module prdct_ctrl
    import prdct_ctrl_pkg::*;
#(
    parameter int DEPTH     = PrdQueueDepth,
    parameter int FLUSH_CYC = FlushCyc,
    parameter int CNT_W     = 32
) (
    input  wire logic   clk,
    input  wire logic   rstn,
    prdct_ctrl_if.slave bus
);

    localparam int FCW = $clog2(FLUSH_CYC + 1);

    state_e           r_state;
    state_e           w_state_nxt;
    logic [FCW-1:0]   r_fcnt;
    logic [FCW-1:0]   w_fcnt_nxt;

    logic             r_redirect;
    inst_addr_t       r_redirect_addr;
    logic [CNT_W-1:0] r_br_cnt;
    logic [CNT_W-1:0] r_mis_cnt;
    logic             r_err;

    logic             w_full;
    logic             w_empty;
    pred_rec_t        w_head;
    pred_rec_t        w_wrec;

    logic             w_idle;
    logic             w_res_valid;
    logic             w_res_empty;
    logic             w_pc_err;
    logic             w_mispred;
    logic             w_correct;
    logic             w_push;

    assign w_idle      = (r_state == ST_IDLE);
    assign w_res_valid = w_idle && bus.ex_resolve_i && !w_empty;
    assign w_res_empty = w_idle && bus.ex_resolve_i &&  w_empty;
    assign w_pc_err    = w_res_valid && (w_head.instaddr != bus.ex_instaddr_i);

    // A PC mismatch is folded into the mispredict so the pipeline recovers.
    assign w_mispred = w_res_valid &&
                       (w_pc_err ||
                        (bus.ex_taken_i != w_head.jump_en) ||
                        (bus.ex_taken_i && (bus.ex_target_i != w_head.target)));
    assign w_correct = w_res_valid && !w_mispred;

    // A push is wrong-path when it coincides with a mispredict; a full queue
    // still accepts it if the head retires correctly in the same cycle.
    assign w_push = w_idle && bus.id_push_i && !w_mispred && (!w_full || w_correct);

    assign w_wrec.jump_en  = bus.id_jump_en_i;
    assign w_wrec.instaddr = bus.id_instaddr_i;
    assign w_wrec.target   = bus.id_target_i;

    prdct_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .i_push  (w_push),
        .i_pop   (w_res_valid),
        .i_clear (w_mispred),
        .i_wdata (w_wrec),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_head  (w_head)
    );

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state <= ST_IDLE;
            r_fcnt  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_fcnt  <= w_fcnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_fcnt_nxt  = r_fcnt;
        case (r_state)
            ST_IDLE: begin
                if (w_mispred) begin
                    w_state_nxt = ST_FLUSH;
                    w_fcnt_nxt  = FCW'(FLUSH_CYC);
                end
            end
            ST_FLUSH: begin
                if (r_fcnt == FCW'(1)) begin
                    w_state_nxt = ST_IDLE;
                    w_fcnt_nxt  = '0;
                end else begin
                    w_fcnt_nxt  = r_fcnt - FCW'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_fcnt_nxt  = '0;
            end
        endcase
    end

    // ---------------- redirect, counters, error ----------------
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_redirect      <= 1'b0;
            r_redirect_addr <= ZeroWord;
            r_br_cnt        <= '0;
            r_mis_cnt       <= '0;
            r_err           <= 1'b0;
        end else begin
            r_redirect <= w_mispred;
            if (w_mispred) begin
                r_redirect_addr <= bus.ex_taken_i ? bus.ex_target_i
                                                  : (bus.ex_instaddr_i + 32'd4);
            end
            if (w_res_valid && (r_br_cnt != '1))
                r_br_cnt <= r_br_cnt + CNT_W'(1);
            if (w_mispred && (r_mis_cnt != '1))
                r_mis_cnt <= r_mis_cnt + CNT_W'(1);
            if (w_res_empty || w_pc_err)
                r_err <= 1'b1;
        end
    end

    assign bus.stall_id_o      = w_full || (r_state == ST_FLUSH);
    assign bus.flush_o         = (r_state == ST_FLUSH);
    assign bus.redirect_o      = r_redirect;
    assign bus.mispred_o       = r_redirect;
    assign bus.redirect_addr_o = r_redirect_addr;
    assign bus.br_cnt_o        = r_br_cnt;
    assign bus.mispred_cnt_o   = r_mis_cnt;
    assign bus.err_o           = r_err;

endmodule : prdct_ctrl
`default_nettype wire

// File: tb/tb_prdct_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_prdct_ctrl                                              |
// | Description : Directed scoreboard bench for prdct_ctrl. Expected         |
// |               redirect targets are queued at stimulus time and popped    |
// |               by a monitor whenever the DUT pulses redirect_o.           |
// | Ports       : none                                                       |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_prdct_ctrl;

    logic clk;
    logic rstn;

    prdct_ctrl_if #(.CNT_W(32)) bus ();

    prdct_ctrl #(
        .DEPTH     (4),
        .FLUSH_CYC (2),
        .CNT_W     (32)
    ) u_dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_vec  = 0;
    int          n_miss = 0;
    logic [31:0] sb_q [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor: every redirect pulse must match the oldest expected target.
    always @(negedge clk) begin
        logic [31:0] e;
        if (bus.redirect_o === 1'b1) begin
            n_vec++;
            if (sb_q.size() == 0) begin
                n_miss++;
                $display("FAIL unexpected_redirect: got addr %h, expected no redirect",
                         bus.redirect_addr_o);
            end else begin
                e = sb_q.pop_front();
                if (bus.redirect_addr_o !== e || bus.mispred_o !== 1'b1) begin
                    n_miss++;
                    $display("FAIL redirect_addr: got %h mispred %b, expected %h mispred 1",
                             bus.redirect_addr_o, bus.mispred_o, e);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic p, input logic pj, input logic [31:0] ppc,
                         input logic [31:0] ptg, input logic r, input logic rt,
                         input logic [31:0] rtg, input logic [31:0] rpc);
        bus.id_push_i     = p;
        bus.id_jump_en_i  = pj;
        bus.id_instaddr_i = ppc;
        bus.id_target_i   = ptg;
        bus.ex_resolve_i  = r;
        bus.ex_taken_i    = rt;
        bus.ex_target_i   = rtg;
        bus.ex_instaddr_i = rpc;
        cyc();
        bus.id_push_i     = 1'b0;
        bus.id_jump_en_i  = 1'b0;
        bus.id_instaddr_i = '0;
        bus.id_target_i   = '0;
        bus.ex_resolve_i  = 1'b0;
        bus.ex_taken_i    = 1'b0;
        bus.ex_target_i   = '0;
        bus.ex_instaddr_i = '0;
    endtask

    task automatic push(input logic j, input logic [31:0] pc, input logic [31:0] tg);
        drive(1'b1, j, pc, tg, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic resolve(input logic t, input logic [31:0] tg, input logic [31:0] pc);
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, t, tg, pc);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_redirect"}, {31'h0, bus.redirect_o}, 32'h0);
        chk({tag, "_raddr"},    bus.redirect_addr_o,      32'h0);
        chk({tag, "_flush"},    {31'h0, bus.flush_o},     32'h0);
        chk({tag, "_mispred"},  {31'h0, bus.mispred_o},   32'h0);
        chk({tag, "_stall"},    {31'h0, bus.stall_id_o},  32'h0);
        chk({tag, "_br_cnt"},   bus.br_cnt_o,             32'h0);
        chk({tag, "_mis_cnt"},  bus.mispred_cnt_o,        32'h0);
        chk({tag, "_err"},      {31'h0, bus.err_o},       32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn              = 1'b0;
        bus.id_push_i     = 1'b0;
        bus.id_jump_en_i  = 1'b0;
        bus.id_instaddr_i = '0;
        bus.id_target_i   = '0;
        bus.ex_resolve_i  = 1'b0;
        bus.ex_taken_i    = 1'b0;
        bus.ex_target_i   = '0;
        bus.ex_instaddr_i = '0;
        cyc();
        cyc();
        chk_all_zero("reset");
        rstn = 1'b1;
        cyc();

        // Backward BEQ predicted taken, resolves taken to same target.
        push(1'b1, 32'h100, 32'h0F0);
        resolve(1'b1, 32'h0F0, 32'h100);
        chk("t1_br_cnt",  bus.br_cnt_o,      32'd1);
        chk("t1_mis_cnt", bus.mispred_cnt_o, 32'd0);
        chk("t1_flush",   {31'h0, bus.flush_o}, 32'h0);

        // Forward BNE predicted not-taken, resolves taken to 0x240.
        push(1'b0, 32'h200, 32'h240);
        sb_q.push_back(32'h240);
        resolve(1'b1, 32'h240, 32'h200);
        chk("t2_flush_c1", {31'h0, bus.flush_o},    32'h1);
        chk("t2_stall_fl", {31'h0, bus.stall_id_o}, 32'h1);
        chk("t2_mis_cnt",  bus.mispred_cnt_o,       32'd1);
        chk("t2_br_cnt",   bus.br_cnt_o,            32'd2);
        // Push and resolve during FLUSH must both be ignored.
        drive(1'b1, 1'b1, 32'h999, 32'h999, 1'b1, 1'b1, 32'h0, 32'h0);
        chk("t2_flush_c2", {31'h0, bus.flush_o},    32'h1);
        chk("t2_redir_c2", {31'h0, bus.redirect_o}, 32'h0);
        cyc();
        chk("t2_flush_end", {31'h0, bus.flush_o},   32'h0);
        chk("t2_br_ignored", bus.br_cnt_o,          32'd2);

        // Three entries; head predicted taken but resolves not-taken.
        push(1'b1, 32'h300, 32'h2F0);
        push(1'b0, 32'h310, 32'h380);
        push(1'b0, 32'h320, 32'h390);
        sb_q.push_back(32'h304);
        resolve(1'b0, 32'h2F0, 32'h300);
        chk("t3_mis_cnt", bus.mispred_cnt_o, 32'd2);
        cyc();
        cyc();
        chk("t3_err_clean", {31'h0, bus.err_o}, 32'h0);

        // Queue must be empty: it takes exactly four pushes to stall.
        push(1'b1, 32'h500, 32'h4F0);
        chk("t5_stall_1", {31'h0, bus.stall_id_o}, 32'h0);
        push(1'b0, 32'h510, 32'h5A0);
        chk("t5_stall_2", {31'h0, bus.stall_id_o}, 32'h0);
        push(1'b1, 32'h520, 32'h530);
        chk("t5_stall_3", {31'h0, bus.stall_id_o}, 32'h0);
        push(1'b0, 32'h530, 32'h000);
        chk("t5_stall_4", {31'h0, bus.stall_id_o}, 32'h1);
        // Fifth push together with a correct resolve of the head.
        drive(1'b1, 1'b1, 32'h540, 32'h500, 1'b1, 1'b1, 32'h4F0, 32'h500);
        chk("t5_stall_5", {31'h0, bus.stall_id_o}, 32'h1);
        chk("t5_br_cnt",  bus.br_cnt_o,            32'd4);
        resolve(1'b0, 32'h5A0, 32'h510);
        chk("t5_stall_drain", {31'h0, bus.stall_id_o}, 32'h0);
        resolve(1'b1, 32'h530, 32'h520);
        resolve(1'b0, 32'h000, 32'h530);
        resolve(1'b1, 32'h500, 32'h540);
        chk("t5_br_final",  bus.br_cnt_o,      32'd8);
        chk("t5_mis_final", bus.mispred_cnt_o, 32'd2);
        chk("t5_err_clean", {31'h0, bus.err_o}, 32'h0);

        // JALR predicted to 0x400, real target 0x404.
        push(1'b1, 32'h380, 32'h400);
        sb_q.push_back(32'h404);
        resolve(1'b1, 32'h404, 32'h380);
        chk("t4_mis_cnt", bus.mispred_cnt_o, 32'd3);
        chk("t4_br_cnt",  bus.br_cnt_o,      32'd9);
        cyc();
        cyc();

        // Resolve on an empty queue.
        resolve(1'b1, 32'h0, 32'h0);
        chk("t6_err_set",  {31'h0, bus.err_o},   32'h1);
        chk("t6_br_same",  bus.br_cnt_o,         32'd9);
        chk("t6_no_flush", {31'h0, bus.flush_o}, 32'h0);
        cyc();
        chk("t6_err_stick", {31'h0, bus.err_o},  32'h1);

        // Enter FLUSH, then reset for one edge in the middle of it.
        push(1'b0, 32'h600, 32'h604);
        sb_q.push_back(32'h640);
        resolve(1'b1, 32'h640, 32'h600);
        chk("t7_in_flush", {31'h0, bus.flush_o}, 32'h1);
        rstn = 1'b0;
        cyc();
        chk_all_zero("t7_rst");
        rstn = 1'b1;
        push(1'b1, 32'h700, 32'h680);
        resolve(1'b1, 32'h680, 32'h700);
        chk("t7_br_after", bus.br_cnt_o,      32'd1);
        chk("t7_mis_after", bus.mispred_cnt_o, 32'd0);

        // Head PC mismatch: error plus recovery redirect.
        push(1'b1, 32'h710, 32'h690);
        sb_q.push_back(32'h690);
        resolve(1'b1, 32'h690, 32'h714);
        chk("t8_err",     {31'h0, bus.err_o},   32'h1);
        chk("t8_mis_cnt", bus.mispred_cnt_o,    32'd1);
        chk("t8_flush",   {31'h0, bus.flush_o}, 32'h1);
        cyc();
        cyc();
        cyc();

        chk("sb_drained", sb_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule : tb_prdct_ctrl
`default_nettype wire
